// File: rtl/qysys_test_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// Ports: clk/reset; m0_*/m1_* slave ports (address, byteenable, read, write,
//   writedata in; waitrequest, readdata, readdatavalid out); mem_* master port
//   (address, byteenable, writedata, chipselect, write, clken out; readdata in).
module qysys_test_onchip_mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic {
        PRI_M0 = 1'b0,
        PRI_M1 = 1'b1
    } pri_t;

    pri_t pri_q, pri_d;

    logic req0, req1;
    logic grant0, grant1, any_grant;
    logic rd_push;

    logic [ADDR_W-1:0] sel_address, address_q;
    logic [BE_W-1:0]   sel_byteenable, byteenable_q;
    logic [DATA_W-1:0] sel_writedata, writedata_q;

    logic [READ_LATENCY-1:0] tag_v, tag_id;
    logic                    out_valid, out_id;
    logic [DATA_W-1:0]       rd0_q, rd1_q;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_ff @(posedge clk) begin
        if (reset) pri_q <= PRI_M0;
        else       pri_q <= pri_d;
    end

    // Grant is combinational in the request cycle; the pointer only
    // names a winner when both masters contend.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        pri_d  = pri_q;
        if (!reset) begin
            if (req0 && (!req1 || pri_q == PRI_M0)) grant0 = 1'b1;
            else if (req1)                          grant1 = 1'b1;
            if (grant0)      pri_d = PRI_M1;
            else if (grant1) pri_d = PRI_M0;
        end
    end

    assign any_grant      = grant0 | grant1;
    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    assign sel_address    = grant1 ? m1_address    : m0_address;
    assign sel_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign sel_writedata  = grant1 ? m1_writedata  : m0_writedata;

    // Memory-side address/data hold their last granted values when idle.
    always_ff @(posedge clk) begin
        if (any_grant) begin
            address_q    <= sel_address;
            byteenable_q <= sel_byteenable;
            writedata_q  <= sel_writedata;
        end
    end

    assign mem_address    = any_grant ? sel_address    : address_q;
    assign mem_byteenable = any_grant ? sel_byteenable : byteenable_q;
    assign mem_writedata  = any_grant ? sel_writedata  : writedata_q;
    assign mem_chipselect = any_grant;
    assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
    assign mem_clken      = ~reset;

    // Read+write together counts as a write and gets no response.
    assign rd_push = (grant0 & m0_read & ~m0_write)
                   | (grant1 & m1_read & ~m1_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= rd_push;
            tag_id[0] <= grant1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign out_valid        = tag_v[READ_LATENCY-1] & ~reset;
    assign out_id           = tag_id[READ_LATENCY-1];
    assign m0_readdatavalid = out_valid & ~out_id;
    assign m1_readdatavalid = out_valid & out_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            if (m0_readdatavalid) rd0_q <= mem_readdata;
            if (m1_readdatavalid) rd1_q <= mem_readdata;
        end
    end

    assign m0_readdata = reset ? '0
                       : (m0_readdatavalid ? mem_readdata : rd0_q);
    assign m1_readdata = reset ? '0
                       : (m1_readdatavalid ? mem_readdata : rd1_q);

endmodule

// File: doc/qysys_test_onchip_mem_arbiter.md
QYSYS_TEST_ONCHIP_MEM_ARBITER -- requirements
Module: qysys_test_onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width of both masters and the memory port.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; the byteenable width SHALL be DATA_W/8.
REQ-003 Parameter READ_LATENCY, default 1, range 1-4, SHALL set the memory read latency in cycles.
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mN_address  in  ADDR_W  master N (N=0,1) word address.
REQ-007 mN_byteenable  in  DATA_W/8  master N byte lanes.
REQ-008 mN_read / mN_write  in  1 each  master N read / write request.
REQ-009 mN_writedata  in  DATA_W  master N write data.
REQ-010 mN_waitrequest  out  1  master N SHALL hold its request while this signal is high.
REQ-011 mN_readdata  out  DATA_W  master N read data.
REQ-012 mN_readdatavalid  out  1  marks mN_readdata valid for one cycle.
REQ-013 mem_address, mem_byteenable, mem_writedata  out  ADDR_W, DATA_W/8, DATA_W  driven from the granted master.
REQ-014 mem_chipselect, mem_write, mem_clken  out  1 each  memory access strobes.
REQ-015 mem_readdata  in  DATA_W  memory read data, valid READ_LATENCY cycles after the address is presented.

Function
REQ-016 A master SHALL be requesting when mN_read|mN_write is high; read and write together SHALL be treated as a write, with no readdatavalid.
REQ-017 Grant SHALL be combinational in the request cycle; at most one master is granted per cycle; the memory SHALL accept one access per cycle with no bubbles.
REQ-018 If one master requests, it SHALL be granted; if both request, the master named by the priority pointer SHALL be granted.
REQ-019 After each grant the pointer SHALL move to the non-granted master; with no grant the pointer SHALL hold.
REQ-020 mN_waitrequest SHALL equal requestN & ~grantN; it SHALL be low when master N is idle.
REQ-021 On grant: mem_chipselect=1; mem_write=granted write; address, byteenable and writedata SHALL be muxed from the granted master.
REQ-022 With no grant: mem_chipselect=0 and mem_write=0; mem_address, mem_byteenable and mem_writedata SHALL hold their last values.
REQ-023 mem_clken SHALL be 1 whenever reset=0.
REQ-024 Each granted read SHALL push {valid, master id} into a READ_LATENCY-deep tag shift register; at the output, mN_readdatavalid SHALL be high only when the id is N.
REQ-025 mN_readdata SHALL be mem_readdata when its valid is high and SHALL hold its last value otherwise.
REQ-026 Read data SHALL return in issue order at exactly READ_LATENCY cycles after the grant, including back-to-back reads from alternating masters.
REQ-027 A write SHALL complete in its grant cycle with no response; a read after a write to the same address SHALL return the new data.

Reset
REQ-028 While reset=1: no grants; both waitrequests equal requestN; mem_chipselect=0, mem_write=0, mem_clken=0; tag register cleared; readdatavalid=0; pointer=m0; readdata=0.
REQ-029 Reads in flight when reset asserts SHALL be discarded; no readdatavalid SHALL appear after reset releases for those reads.
REQ-030 The first cycle after reset deasserts SHALL arbitrate normally.

Verification
REQ-031 m0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then reads 0x005 -> m0_readdatavalid 1 cycle after the read grant with 0xDEADBEEF; m1_readdatavalid stays 0.
REQ-032 m0 and m1 both read continuously from reset -> grants alternate m0, m1, m0, ...; each master's waitrequest is high every other cycle; data returns to the correct master in order.
REQ-033 m1 writes 0x11223344 with byteenable 0x3 over 0xFFFFFFFF at address 0x3FF (wrap-limit address) -> a later read returns 0xFFFF3344.
REQ-034 Only m1 requests while the pointer favours m0 -> m1 is granted immediately with waitrequest=0, and the pointer moves to m0.
REQ-035 Reset is asserted in the cycle after an m0 read grant -> no readdatavalid on either master; the first access after reset goes to m0 when both request.
REQ-036 READ_LATENCY=3 with 4 back-to-back reads alternating m0, m1 -> four readdatavalid pulses on consecutive cycles 3 cycles after each grant, with correct master routing.
